// File: rtl/seq_mul16.sv
// Iterative 16x16 shift-add multiplier: 32-bit product after 16 RUN cycles, start/busy/done handshake.
// Optional two's-complement support is compiled in with `define SEQ_MUL_SIGNED_EN.
module seq_mul16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic        signed_op,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] prod_lo,
    output logic [15:0] prod_hi
);

    // Handshake: start is accepted only in IDLE or DONE; busy marks the 16
    // iteration cycles; done is a single-cycle pulse with the product valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_load;
    logic        w_finish;

    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [16:0] r_mplr;
    logic [3:0]  r_count;
    logic [31:0] r_prod;

    logic [31:0] w_sum;
    logic [31:0] w_prod;
    logic [31:0] w_mcand_ld;
    logic [16:0] w_mplr_ld;

`ifdef SEQ_MUL_SIGNED_EN
    logic        r_sign;
    logic        w_sign_ld;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [16:0] w_a_ext;
    logic [16:0] w_b_ext;
    logic [16:0] w_a_mag;
    logic [16:0] w_b_mag;

    // 17-bit sign extension keeps |0x8000| = 32768 representable.
    assign w_a_neg    = signed_op & a[15];
    assign w_b_neg    = signed_op & b[15];
    assign w_a_ext    = {w_a_neg, a};
    assign w_b_ext    = {w_b_neg, b};
    assign w_a_mag    = w_a_neg ? (17'd0 - w_a_ext) : w_a_ext;
    assign w_b_mag    = w_b_neg ? (17'd0 - w_b_ext) : w_b_ext;
    assign w_sign_ld  = w_a_neg ^ w_b_neg;
    assign w_mcand_ld = {15'd0, w_a_mag};
    assign w_mplr_ld  = w_b_mag;
    assign w_prod     = r_sign ? (32'd0 - w_sum) : w_sum;
`else
    assign w_mcand_ld = {16'd0, a};
    assign w_mplr_ld  = {1'b0, b};
    assign w_prod     = w_sum;
`endif

    // Partial product of the current iteration; on the last RUN cycle this is the final sum.
    assign w_sum = r_acc + (r_mplr[0] ? r_mcand : 32'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (r_count == 4'd15) begin
                    w_state_nxt = S_DONE;
                    w_finish    = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= 32'd0;
            r_mcand <= 32'd0;
            r_mplr  <= 17'd0;
            r_count <= 4'd0;
            r_prod  <= 32'd0;
`ifdef SEQ_MUL_SIGNED_EN
            r_sign  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_acc   <= 32'd0;
                r_mcand <= w_mcand_ld;
                r_mplr  <= w_mplr_ld;
                r_count <= 4'd0;
`ifdef SEQ_MUL_SIGNED_EN
                r_sign  <= w_sign_ld;
`endif
            end else if (r_state == S_RUN) begin
                r_acc   <= w_sum;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_count <= r_count + 4'd1;
            end
            // Product register only moves on RUN->DONE, so it holds across a following RUN.
            if (w_finish) begin
                r_prod <= w_prod;
            end
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign prod_lo = r_prod[15:0];
    assign prod_hi = r_prod[31:16];

endmodule

// File: tb/tb_seq_mul16.sv
// Self-checking bench for seq_mul16: directed vectors, expected products and done cycles queued
// by the driver and consumed by a done-triggered monitor.
module tb_seq_mul16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
`ifdef SEQ_MUL_SIGNED_EN
  logic        signed_op;
`endif
  logic        busy;
  logic        done;
  logic [15:0] prod_lo;
  logic [15:0] prod_hi;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Entry: {expected product, cycle counter value at which done must be seen}
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  seq_mul16 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy    (busy),
    .done    (done),
    .prod_lo (prod_lo),
    .prod_hi (prod_hi)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("busy_done_exclusive", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cyc %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("product", {prod_hi, prod_lo}, mon_e[63:32]);
        check("done_cycle", 32'(cyc), mon_e[31:0]);
      end
    end
  end

  // drivers: called at a negedge; start is sampled on the following posedge
  task automatic drive_start(input logic [15:0] ta, input logic [15:0] tb_v,
                             input bit accept, input logic [31:0] exp_p);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    if (accept) exp_q.push_back({exp_p, 32'(cyc + 17)});
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom_range(0, 16'hFFFF));
    b     = 16'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic busy_phase(input int inject_at, input bit chk_hold, input logic [15:0] hold_lo);
    for (int i = 0; i < 16; i++) begin
      check("busy_in_run", {31'd0, busy}, 32'd1);
      if (chk_hold) check("prod_lo_hold", {16'd0, prod_lo}, {16'd0, hold_lo});
      if (i == inject_at) begin
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [31:0] exp_p);
    drive_start(ta, tb_v, 1'b1, exp_p);
    busy_phase(-1, 1'b0, 16'h0);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
`ifdef SEQ_MUL_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_prod_lo", {16'd0, prod_lo}, 32'd0);
    check("reset_prod_hi", {16'd0, prod_hi}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op(16'd3, 16'd5, 32'h0000_000F);
    op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    op(16'h1234, 16'h0000, 32'h0000_0000);

    // start while busy is ignored
    drive_start(16'd2, 16'd2, 1'b1, 32'h0000_0004);
    busy_phase(4, 1'b0, 16'h0);
    repeat (20) @(negedge clk);
    check("idle_after_ignored_start", {30'd0, busy, done}, 32'd0);

    // reset mid-operation aborts with no done
    drive_start(16'h00FF, 16'h0101, 1'b0, 32'h0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_prod", {prod_hi, prod_lo}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    op(16'd4, 16'd4, 32'h0000_0010);

    // back-to-back: second start during the done cycle
    drive_start(16'd10, 16'd10, 1'b1, 32'h0000_0064);
    busy_phase(-1, 1'b0, 16'h0);
    drive_start(16'd6, 16'd7, 1'b1, 32'h0000_002A);
    busy_phase(-1, 1'b1, 16'h0064);
    @(negedge clk);
    check("idle_after_b2b", {30'd0, busy, done}, 32'd0);

`ifdef SEQ_MUL_SIGNED_EN
    signed_op = 1'b1;
    op(16'hFFFE, 16'h0003, 32'hFFFF_FFFA);
    op(16'h8000, 16'h8000, 32'h4000_0000);
    signed_op = 1'b0;
    op(16'hFFFE, 16'h0003, 32'h0002_FFFA);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
